// File: rtl/ifft_frame_capture.sv
// ifft_frame_capture: ping-pong capture of IFFT output frames, drained as a valid/ready stream
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_ce, i_sync, i_result  IFFT sample strobe, first-of-frame marker, sample
//   o_valid, i_ready        downstream handshake
//   o_data, o_last          drained sample in frame order, last-of-frame marker
//   o_overflow, o_sync_err  sticky: frame dropped for lack of a bank, frame alignment broken
module ifft_frame_capture #(
   parameter int LGSIZE = 11,
   parameter int DW     = 32
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_ce,
   input  logic          i_sync,
   input  logic [DW-1:0] i_result,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [DW-1:0] o_data,
   output logic          o_last,
   output logic          o_overflow,
   output logic          o_sync_err
);
   localparam logic [LGSIZE-1:0] LAST = '1;

   typedef enum logic [1:0] {IDLE, FILL, DROP} state_t;

   state_t            r_state;
   logic [LGSIZE-1:0] r_wcnt, r_ridx;
   logic              r_wb, r_rb, r_done, r_issued, r_qv, r_qlast, r_overflow, r_sync_err;
   logic [1:0]        r_full;
   logic [DW-1:0]     r_mem [0:(2<<LGSIZE)-1];
   logic [DW-1:0]     r_q;
   logic              w_we, w_fill_done, w_adv, w_issue, w_last_acc;
   logic [LGSIZE:0]   w_waddr, w_raddr;

   // a sync always lands at index 0; otherwise only FILL stores
   assign w_we        = i_ce && (i_sync ? !r_full[r_wb] : r_state == FILL);
   assign w_waddr     = {r_wb, i_sync ? {LGSIZE{1'b0}} : r_wcnt};
   assign w_fill_done = i_ce && !i_sync && r_state == FILL && r_wcnt == LAST;
   // read register and output register advance together, so a stall freezes both
   assign w_adv       = !o_valid || i_ready;
   assign w_issue     = w_adv && r_full[r_rb] && !r_issued;
   assign w_raddr     = {r_rb, r_ridx};
   assign w_last_acc  = o_valid && i_ready && o_last;
   assign o_overflow  = r_overflow;
   assign o_sync_err  = r_sync_err;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_wcnt     <= '0;
         r_wb       <= 1'b0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
         r_sync_err <= 1'b0;
      end else if (i_ce) begin
         // remembers that this sample closed a frame, so the next one must be a sync
         r_done <= r_state != IDLE && !i_sync && r_wcnt == LAST;
         if (i_sync) begin
            if (r_state != IDLE && r_wcnt != '0)
               r_sync_err <= 1'b1;
            r_wcnt <= LGSIZE'(1);
            if (r_full[r_wb]) begin
               r_overflow <= 1'b1;
               r_state    <= DROP;
            end else
               r_state <= FILL;
         end else if (r_state == IDLE) begin
            if (r_done)
               r_sync_err <= 1'b1;
         end else begin
            r_wcnt <= r_wcnt + 1'b1;
            if (r_wcnt == LAST) begin
               r_state <= IDLE;
               if (r_state == FILL)
                  r_wb <= ~r_wb;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_full   <= 2'b00;
         r_rb     <= 1'b0;
         r_ridx   <= '0;
         r_issued <= 1'b0;
         r_qv     <= 1'b0;
         r_qlast  <= 1'b0;
         o_valid  <= 1'b0;
         o_last   <= 1'b0;
         o_data   <= '0;
      end else begin
         // set and clear always address different banks
         if (w_fill_done)
            r_full[r_wb] <= 1'b1;
         if (w_last_acc) begin
            r_full[r_rb] <= 1'b0;
            r_rb         <= ~r_rb;
            r_issued     <= 1'b0;
         end
         if (w_issue) begin
            r_ridx  <= r_ridx + 1'b1;
            r_qlast <= r_ridx == LAST;
            if (r_ridx == LAST)
               r_issued <= 1'b1;
         end
         if (w_adv) begin
            r_qv    <= w_issue;
            o_valid <= r_qv;
            o_last  <= r_qv && r_qlast;
            if (r_qv)
               o_data <= r_q;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_we)
         r_mem[w_waddr] <= i_result;
      if (w_issue)
         r_q <= r_mem[w_raddr];
   end
endmodule

// File: tb/tb_ifft_frame_capture.sv
// tb_ifft_frame_capture: randomized scoreboard bench for ifft_frame_capture at LGSIZE 3 and 11
module tb_ifft_frame_capture;
   localparam int DW = 32;

   logic          clk = 1'b0, rst = 1'b0, ce = 1'b0, sync = 1'b0, ready = 1'b1;
   logic [DW-1:0] result = '0;
   logic          v3, l3, ov3, se3, v11, l11, ov11, se11;
   logic [DW-1:0] d3, d11;
   logic          big = 1'b0, rr = 1'b0;
   logic          vld, lst, ovf, serr;
   logic [DW-1:0] dat;
   int            N;

   int            n_chk = 0, n_fail = 0;
   logic [DW-1:0] exp_q[$], cur[$], got[$];
   bit            gotl[$];
   int            cur_n = 0, banks = 0, beat = 0;
   bit            dropping = 0, m_ovf = 0, m_serr = 0, m_done = 0;

   always #5 clk = ~clk;

   ifft_frame_capture #(.LGSIZE(3), .DW(DW)) dut3 (
      .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_sync(sync), .i_result(result),
      .o_valid(v3), .i_ready(ready), .o_data(d3), .o_last(l3),
      .o_overflow(ov3), .o_sync_err(se3));

   ifft_frame_capture #(.LGSIZE(11), .DW(DW)) dut11 (
      .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_sync(sync), .i_result(result),
      .o_valid(v11), .i_ready(ready), .o_data(d11), .o_last(l11),
      .o_overflow(ov11), .o_sync_err(se11));

   assign vld  = big ? v11 : v3;
   assign lst  = big ? l11 : l3;
   assign dat  = big ? d11 : d3;
   assign ovf  = big ? ov11 : ov3;
   assign serr = big ? se11 : se3;
   assign N    = big ? 2048 : 8;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
      end
   endtask

   // frame-level model: banks in use, queue of frames awaiting drain, sticky flags
   initial begin : model
      bit prev;
      int b0;
      forever begin
         @(posedge clk);
         if (rst) begin
            exp_q.delete(); cur.delete();
            cur_n = 0; banks = 0; beat = 0; dropping = 0;
            m_ovf = 0; m_serr = 0; m_done = 0;
         end else begin
            b0 = banks;
            if (vld && ready) begin
               got.push_back(dat); gotl.push_back(lst);
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               beat++;
               if (beat == N) begin beat = 0; banks--; end
            end
            if (ce) begin
               prev = m_done; m_done = 0;
               if (sync) begin
                  if (cur_n > 0) m_serr = 1;
                  cur.delete(); cur_n = 1; dropping = (b0 == 2);
                  if (dropping) m_ovf = 1; else cur.push_back(result);
               end else if (cur_n > 0) begin
                  if (!dropping) cur.push_back(result);
                  cur_n++;
                  if (cur_n == N) begin
                     if (!dropping) begin
                        foreach (cur[i]) exp_q.push_back(cur[i]);
                        banks++;
                     end
                     cur.delete(); cur_n = 0; m_done = 1;
                  end
               end else if (prev) m_serr = 1;
            end
         end
      end
   end

   initial begin : compare
      int idle;
      idle = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("overflow", ovf, m_ovf);
            chk("sync_err", serr, m_serr);
            if (vld) begin
               idle = 0;
               if (exp_q.size() == 0) chk("beat_without_frame", vld, 0);
               else begin
                  chk("data", dat, exp_q[0]);
                  chk("last", lst, beat == N - 1);
               end
            end else if (banks > 0) begin
               idle++;
               if (idle > 3) chk("drain_idle_cycles", idle, 3);
            end else idle = 0;
         end
      end
   end

   task automatic cyc(input bit c, input bit s, input logic [31:0] d);
      ce = c; sync = s; result = d;
      if (rr) ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
   endtask

   task automatic send_frame(input logic [31:0] base, input logic [31:0] step, input bit gaps, input bit wf);
      for (int k = 0; wf && banks == 2 && k < 5000; k++) cyc(0, 0, $urandom);
      for (int i = 0; i < N; i++) begin
         while (gaps && $urandom_range(0, 1) == 1) cyc(0, 0, $urandom);
         cyc(1, i == 0, base + step * i);
      end
      ce = 0; sync = 0;
   endtask

   task automatic wait_drain(input string nm, input int lim);
      for (int k = 0; (exp_q.size() > 0 || vld) && k < lim; k++) cyc(0, 0, $urandom);
      chk(nm, exp_q.size(), 0);
   endtask

   task automatic do_reset(input string nm);
      ce = 0; sync = 0; rst = 1; #1;
      chk({nm, "_valid"}, vld, 0);
      chk({nm, "_data"}, dat, 0);
      chk({nm, "_last"}, lst, 0);
      chk({nm, "_overflow"}, ovf, 0);
      chk({nm, "_sync_err"}, serr, 0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: run still active at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      #2;
      do_reset("reset");

      // single frame, steady ready
      got.delete(); gotl.delete();
      send_frame(32'h0001_0000, 32'h0001_0000, 0, 1);
      wait_drain("t31_drain", 100);
      chk("t31_count", got.size(), 8);
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         chk("t31_data", got[i], 32'h0001_0000 * (i + 1));
         chk("t31_last", gotl[i], i == 7);
      end
      chk("t31_overflow", ovf, 0);
      chk("t31_sync_err", serr, 0);

      // three frames with no drain: third must be dropped
      got.delete(); gotl.delete();
      ready = 0;
      send_frame(32'h0A00_0000, 1, 0, 0);
      send_frame(32'h0B00_0000, 1, 0, 0);
      send_frame(32'h0C00_0000, 1, 0, 0);
      repeat (5) cyc(0, 0, $urandom);
      chk("t32_overflow", ovf, 1);
      chk("t32_held_valid", vld, 1);
      chk("t32_no_beats", got.size(), 0);
      ready = 1;
      wait_drain("t32_drain", 100);
      chk("t32_count", got.size(), 16);
      for (int i = 0; i < 16 && i < got.size(); i++)
         chk("t32_data", got[i], i < 8 ? 32'h0A00_0000 + i : 32'h0B00_0000 + i - 8);
      do_reset("t32_reset");

      // sync arriving at index 4 restarts the frame there
      got.delete(); gotl.delete();
      for (int i = 0; i < 4; i++) cyc(1, i == 0, 32'h3000_0000 + i);
      send_frame(32'h3100_0000, 1, 0, 1);
      wait_drain("t33_drain", 100);
      chk("t33_sync_err", serr, 1);
      chk("t33_count", got.size(), 8);
      for (int i = 0; i < 8 && i < got.size(); i++)
         chk("t33_data", got[i], 32'h3100_0000 + i);
      do_reset("t33_reset");

      // random ready and sample gaps over 20 frames
      got.delete(); gotl.delete();
      rr = 1;
      for (int f = 0; f < 20; f++) send_frame($urandom, $urandom, 1, 1);
      rr = 0; ready = 1;
      wait_drain("t34_drain", 200);
      chk("t34_count", got.size(), 160);
      chk("t34_overflow", ovf, 0);
      chk("t34_sync_err", serr, 0);

      // full-size instance: reset mid-write and mid-drain
      big = 1;
      do_reset("t35_reset0");
      got.delete(); gotl.delete();
      for (int i = 0; i < 3; i++) cyc(1, 0, $urandom);
      for (int i = 0; i < 1000; i++) cyc(1, i == 0, 32'h5000_0000 + i);
      do_reset("t35_reset_write");
      repeat (10) cyc(0, 0, $urandom);
      chk("t35_no_beats_after_write_reset", got.size(), 0);
      send_frame(32'h6000_0000, 1, 0, 1);
      for (int k = 0; got.size() < 500 && k < 5000; k++) cyc(0, 0, $urandom);
      chk("t35_beats_before_drain_reset", got.size(), 500);
      do_reset("t35_reset_drain");
      got.delete(); gotl.delete();
      repeat (10) cyc(0, 0, $urandom);
      chk("t35_idle_after_drain_reset", vld, 0);
      for (int i = 0; i < 5; i++) cyc(1, 0, $urandom);
      send_frame(32'h7000_0000, 3, 1, 1);
      wait_drain("t35_drain", 5000);
      chk("t35_count", got.size(), 2048);
      if (got.size() == 2048) begin
         chk("t35_first", got[0], 32'h7000_0000);
         chk("t35_final", got[2047], 32'h7000_0000 + 3 * 2047);
         chk("t35_final_last", gotl[2047], 1);
         chk("t35_early_last", gotl[2046], 0);
      end
      chk("t35_sync_err", serr, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ifft_frame_capture.md
IFFT_FRAME_CAPTURE -- requirements
Module: ifft_frame_capture

Interface
REQ-001 SHALL have parameter LGSIZE, default 11, log2 of frame length (2048 samples).
REQ-002 SHALL have parameter DW, default 32, sample width (16-bit real in high half, 16-bit imag in low half).
REQ-003 i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 i_reset  input  1  reset, asynchronous, active-high.
REQ-005 i_ce  input  1  sample strobe from IFFT output; one sample per high cycle.
REQ-006 i_sync  input  1  qualifies first sample of a frame; meaningful only with i_ce.
REQ-007 i_result  input  DW  IFFT output sample.
REQ-008 o_valid  output  1  o_data holds a valid beat.
REQ-009 i_ready  input  1  downstream accepts beat when o_valid && i_ready.
REQ-010 o_data  output  DW  drained sample, frame order, index 0 first.
REQ-011 o_last  output  1  high with beat index 2^LGSIZE-1.
REQ-012 o_overflow  output  1  sticky: a whole frame was dropped, no free bank.
REQ-013 o_sync_err  output  1  sticky: frame alignment violated.

Function
REQ-014 SHALL store frames in a ping-pong buffer of two banks, each 2^LGSIZE x DW, with per-bank full flags; write bank pointer wb, read bank pointer rb.
REQ-015 Capture FSM states SHALL be IDLE, FILL, DROP; write counter wcnt LGSIZE bits.
REQ-016 IDLE: i_ce && i_sync with full[wb]==0 -> write sample at address 0, wcnt=1, FILL; with full[wb]==1 -> set o_overflow, wcnt=1, DROP; i_ce && !i_sync -> discard.
REQ-017 FILL: each i_ce && !i_sync writes at wcnt, wcnt++; write of index 2^LGSIZE-1 sets full[wb], toggles wb, returns to IDLE.
REQ-018 FILL/DROP: i_ce && i_sync with wcnt!=0 -> set o_sync_err, abandon partial frame (bank not marked full), treat sample exactly as an IDLE sync per REQ-016.
REQ-019 DROP: count i_ce samples without storing; after index 2^LGSIZE-1 return to IDLE.
REQ-020 o_sync_err SHALL also set on i_ce && !i_sync in IDLE when the immediately preceding i_ce sample completed a frame (FILL or DROP).
REQ-021 Drain side: when full[rb]==1 and not draining, SHALL read bank rb index 0..2^LGSIZE-1 in order with 1-cycle memory read latency plus output register; first o_valid within 3 cycles of full[rb] rising.
REQ-022 While o_valid && !i_ready, o_data and o_last SHALL hold stable; no beat dropped or duplicated; throughput one beat per cycle while i_ready stays high.
REQ-023 Acceptance of the o_last beat SHALL clear full[rb], toggle rb, deassert o_valid unless the other bank is already full, in which case draining continues with no more than 2 idle cycles.
REQ-024 Set of full[wb] and clear of full[rb] in the same cycle SHALL both take effect.
REQ-025 Writer SHALL never write a bank with full==1; reader SHALL never read a bank with full==0.
REQ-026 i_ce low SHALL freeze capture FSM and wcnt; drain side is independent of i_ce.
REQ-027 Sticky flags SHALL clear only on reset.

Reset
REQ-028 i_reset high SHALL immediately clear: FSM to IDLE, wcnt=0, wb=0, rb=0, full=00, o_valid=0, o_last=0, o_data=0, o_overflow=0, o_sync_err=0.
REQ-029 Reset mid-frame or mid-drain SHALL discard all buffered data; first frame after reset requires a fresh i_sync.
REQ-030 Memory contents need not be reset.

Verification
REQ-031 LGSIZE=3, i_ready=1: 8 samples 0x00010000..0x00080000, sync on first, i_ce every cycle -> 8 beats in order, o_last on 0x00080000 only, flags 0.
REQ-032 LGSIZE=3, i_ready=0: three back-to-back synced frames -> frames 1,2 held, frame 3 dropped, o_overflow=1; raise i_ready -> exactly 16 beats, frames 1 then 2.
REQ-033 LGSIZE=3: i_sync at sample index 4 of a frame -> o_sync_err=1, partial discarded, new frame starts at that sample, 8 beats output from it.
REQ-034 LGSIZE=3: i_ready toggled pseudo-randomly, i_ce 50% duty, 20 frames -> output equals input in order, no stall-time data change, flags 0.
REQ-035 LGSIZE=11: assert i_reset at write index 1000 and again at drain beat 500 -> all outputs 0 immediately; next synced 2048-sample frame drains intact.
